// File: rtl/regfile_seq_pkg.sv
// Shared opcode encodings and FSM state type for the register-file sequencer.
package regfile_seq_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MOV = 3'b101;
    localparam logic [2:0] OP_LDI = 3'b110;
    localparam logic [2:0] OP_CLR = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WB    = 2'd2,
        ST_CLEAR = 2'd3
    } state_e;

endpackage

// File: rtl/regfile_sequencer_if.sv
// Command handshake plus register-file address/data ports of the sequencer.
// master = sequencer side, slave = front-end and register file side.
interface regfile_sequencer_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int REG_WIDTH  = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [2:0]            cmd_op;
    logic [ADDR_WIDTH-1:0] cmd_rd;
    logic [ADDR_WIDTH-1:0] cmd_rs1;
    logic [ADDR_WIDTH-1:0] cmd_rs2;
    logic [REG_WIDTH-1:0]  cmd_imm;
    logic [ADDR_WIDTH-1:0] rf_read_1_addr;
    logic [ADDR_WIDTH-1:0] rf_read_2_addr;
    logic [REG_WIDTH-1:0]  rf_read_bus_1;
    logic [REG_WIDTH-1:0]  rf_read_bus_2;
    logic [ADDR_WIDTH-1:0] rf_write_addr;
    logic [REG_WIDTH-1:0]  rf_write_bus;
    logic                  rf_write_enabled;
    logic                  done;
    logic                  carry;
    logic                  zero;

    modport master (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        input  rf_read_bus_1, rf_read_bus_2,
        output cmd_ready, rf_read_1_addr, rf_read_2_addr,
        output rf_write_addr, rf_write_bus, rf_write_enabled,
        output done, carry, zero
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        output rf_read_bus_1, rf_read_bus_2,
        input  cmd_ready, rf_read_1_addr, rf_read_2_addr,
        input  rf_write_addr, rf_write_bus, rf_write_enabled,
        input  done, carry, zero
    );

endinterface

// File: rtl/seq_alu.sv
// Combinational ALU: (op, a, b, imm) -> (result, carry, zero), all modulo 2**REG_WIDTH.
// SUB reports borrow on carry; CLR yields a zero result and is never used for flags.
module seq_alu
    import regfile_seq_pkg::*;
#(
    parameter int REG_WIDTH = 8
) (
    input  logic [2:0]           i_op,
    input  logic [REG_WIDTH-1:0] i_a,
    input  logic [REG_WIDTH-1:0] i_b,
    input  logic [REG_WIDTH-1:0] i_imm,
    output logic [REG_WIDTH-1:0] o_result,
    output logic                 o_carry,
    output logic                 o_zero
);

    logic [REG_WIDTH:0] w_wide;

    always_comb begin
        w_wide   = '0;
        o_result = '0;
        o_carry  = 1'b0;
        case (i_op)
            OP_ADD: begin
                w_wide   = {1'b0, i_a} + {1'b0, i_b};
                o_result = w_wide[REG_WIDTH-1:0];
                o_carry  = w_wide[REG_WIDTH];
            end
            OP_SUB: begin
                // Top bit of the widened difference is the borrow (a < b unsigned).
                w_wide   = {1'b0, i_a} - {1'b0, i_b};
                o_result = w_wide[REG_WIDTH-1:0];
                o_carry  = w_wide[REG_WIDTH];
            end
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            OP_MOV:  o_result = i_a;
            OP_LDI:  o_result = i_imm;
            default: o_result = '0;
        endcase
        o_zero = (o_result == '0);
    end

endmodule

// File: rtl/regfile_sequencer.sv
// Command-driven initiator for a 2R/1W register file: READ -> ALU -> single-cycle write-back, plus CLR sweep.
// Latency: ALU/MOV done in cycle 2, LDI in cycle 1, CLR in cycle N after accept; one command in flight.
module regfile_sequencer
    import regfile_seq_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int REG_WIDTH  = 8
) (
    input  logic                clk,
    input  logic                reset,
    regfile_sequencer_if.master bus
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_WIDTH-1:0] ONE_ADDR  = ADDR_WIDTH'(1);

    state_e                r_state;
    logic [2:0]            r_op;
    logic [ADDR_WIDTH-1:0] r_rd;
    logic [ADDR_WIDTH-1:0] r_rd1_addr;
    logic [ADDR_WIDTH-1:0] r_rd2_addr;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [REG_WIDTH-1:0]  r_wr_bus;
    logic                  r_we;
    logic                  r_done;
    logic                  r_carry;
    logic                  r_zero;

    logic [2:0]            w_alu_op;
    logic [REG_WIDTH-1:0]  w_alu_result;
    logic                  w_alu_carry;
    logic                  w_alu_zero;

    // In IDLE the ALU evaluates the incoming command so LDI can write back on the next cycle.
    assign w_alu_op = (r_state == ST_IDLE) ? bus.cmd_op : r_op;

    seq_alu #(.REG_WIDTH(REG_WIDTH)) u_alu (
        .i_op     (w_alu_op),
        .i_a      (bus.rf_read_bus_1),
        .i_b      (bus.rf_read_bus_2),
        .i_imm    (bus.cmd_imm),
        .o_result (w_alu_result),
        .o_carry  (w_alu_carry),
        .o_zero   (w_alu_zero)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_op       <= OP_ADD;
            r_rd       <= '0;
            r_rd1_addr <= '0;
            r_rd2_addr <= '0;
            r_wr_addr  <= '0;
            r_wr_bus   <= '0;
            r_we       <= 1'b0;
            r_done     <= 1'b0;
            r_carry    <= 1'b0;
            r_zero     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_we   <= 1'b0;
                    r_done <= 1'b0;
                    if (bus.cmd_valid) begin
                        r_op <= bus.cmd_op;
                        r_rd <= bus.cmd_rd;
                        case (bus.cmd_op)
                            OP_LDI: begin
                                r_state   <= ST_WB;
                                r_wr_addr <= bus.cmd_rd;
                                r_wr_bus  <= w_alu_result;
                                r_carry   <= w_alu_carry;
                                r_zero    <= w_alu_zero;
                                r_we      <= 1'b1;
                                r_done    <= 1'b1;
                            end
                            OP_CLR: begin
                                r_state   <= ST_CLEAR;
                                r_wr_addr <= '0;
                                r_wr_bus  <= '0;
                                r_we      <= 1'b1;
                            end
                            default: begin
                                r_state    <= ST_READ;
                                r_rd1_addr <= bus.cmd_rs1;
                                r_rd2_addr <= bus.cmd_rs2;
                            end
                        endcase
                    end
                end
                ST_READ: begin
                    r_state   <= ST_WB;
                    r_wr_addr <= r_rd;
                    r_wr_bus  <= w_alu_result;
                    r_carry   <= w_alu_carry;
                    r_zero    <= w_alu_zero;
                    r_we      <= 1'b1;
                    r_done    <= 1'b1;
                end
                ST_WB: begin
                    r_state <= ST_IDLE;
                    r_we    <= 1'b0;
                    r_done  <= 1'b0;
                end
                ST_CLEAR: begin
                    // The write address register doubles as the sweep counter.
                    if (r_wr_addr == LAST_ADDR) begin
                        r_state <= ST_IDLE;
                        r_we    <= 1'b0;
                        r_done  <= 1'b0;
                    end else begin
                        r_wr_addr <= r_wr_addr + ONE_ADDR;
                        r_we      <= 1'b1;
                        r_done    <= (r_wr_addr == LAST_ADDR - ONE_ADDR);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_we    <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready        = (r_state == ST_IDLE) && reset;
    assign bus.rf_read_1_addr   = r_rd1_addr;
    assign bus.rf_read_2_addr   = r_rd2_addr;
    assign bus.rf_write_addr    = r_wr_addr;
    assign bus.rf_write_bus     = r_wr_bus;
    assign bus.rf_write_enabled = r_we;
    assign bus.done             = r_done;
    assign bus.carry            = r_carry;
    assign bus.zero             = r_zero;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer with a behavioural 32x8 register file and write monitor.
module tb_regfile_sequencer;
    import regfile_seq_pkg::*;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    logic [7:0]  rf [32];
    logic        rf_fill;
    logic        mon_clr;
    logic [31:0] wr_seen;
    int          wr_cnt;
    int          done_cnt;

    regfile_sequencer_if #(.ADDR_WIDTH(5), .REG_WIDTH(8)) bus ();

    regfile_sequencer #(.ADDR_WIDTH(5), .REG_WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.rf_read_bus_1 = rf[bus.rf_read_1_addr];
    assign bus.rf_read_bus_2 = rf[bus.rf_read_2_addr];

    always @(posedge clk) begin
        if (rf_fill) begin
            for (int i = 0; i < 32; i++) rf[i] <= 8'hA5;
        end else if (bus.rf_write_enabled) begin
            rf[bus.rf_write_addr] <= bus.rf_write_bus;
        end
        if (mon_clr) begin
            wr_seen  <= '0;
            wr_cnt   <= 0;
            done_cnt <= 0;
        end else begin
            if (bus.rf_write_enabled) begin
                wr_seen[bus.rf_write_addr] <= 1'b1;
                wr_cnt <= wr_cnt + 1;
            end
            if (bus.done) done_cnt <= done_cnt + 1;
        end
    end

    // Returns at the negedge of cycle 1 after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [7:0] imm, input bit hold);
        int k;
        k = 0;
        @(negedge clk);
        bus.cmd_op = op; bus.cmd_rd = rd; bus.cmd_rs1 = rs1; bus.cmd_rs2 = rs2; bus.cmd_imm = imm;
        bus.cmd_valid = 1'b1;
        while (!bus.cmd_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (bus.cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL accept_timeout op=%0d ready=%b required 1", op, bus.cmd_ready);
        end
        @(posedge clk);
        @(negedge clk);
        if (!hold) bus.cmd_valid = 1'b0;
    endtask

    task automatic clear_monitor();
        mon_clr = 1'b1;
        @(negedge clk);
        mon_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; rf_fill = 1'b1; mon_clr = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_op = OP_ADD; bus.cmd_rd = '0;
        bus.cmd_rs1 = '0; bus.cmd_rs2 = '0; bus.cmd_imm = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (bus.cmd_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready got=%b exp=0", bus.cmd_ready); end
        n_cmp++; if (bus.rf_write_enabled !== 1'b0) begin n_err++; $display("FAIL rst_we got=%b exp=0", bus.rf_write_enabled); end
        n_cmp++; if ({bus.done, bus.carry, bus.zero} !== 3'b000) begin n_err++; $display("FAIL rst_flags got=%b exp=000", {bus.done, bus.carry, bus.zero}); end
        n_cmp++; if ({bus.rf_read_1_addr, bus.rf_read_2_addr, bus.rf_write_addr, bus.rf_write_bus} !== 23'h0) begin
            n_err++; $display("FAIL rst_buses got=%h exp=0", {bus.rf_read_1_addr, bus.rf_read_2_addr, bus.rf_write_addr, bus.rf_write_bus});
        end
        reset = 1'b1; rf_fill = 1'b0; mon_clr = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready got=%b exp=1", bus.cmd_ready); end
    endtask

    task automatic test_ldi_add();
        issue(OP_LDI, 5'd3, 5'd0, 5'd0, 8'h7F, 1'b0);
        n_cmp++; if ({bus.rf_write_enabled, bus.done, bus.rf_write_addr, bus.rf_write_bus} !== {1'b1, 1'b1, 5'd3, 8'h7F}) begin
            n_err++; $display("FAIL ldi_wb got we=%b done=%b a=%0d d=%h exp 1 1 3 7f", bus.rf_write_enabled, bus.done, bus.rf_write_addr, bus.rf_write_bus);
        end
        issue(OP_LDI, 5'd4, 5'd0, 5'd0, 8'h01, 1'b0);
        clear_monitor();
        issue(OP_ADD, 5'd5, 5'd3, 5'd4, 8'h00, 1'b0);
        n_cmp++; if ({bus.rf_write_enabled, bus.rf_read_1_addr, bus.rf_read_2_addr} !== {1'b0, 5'd3, 5'd4}) begin
            n_err++; $display("FAIL add_read got we=%b r1=%0d r2=%0d exp 0 3 4", bus.rf_write_enabled, bus.rf_read_1_addr, bus.rf_read_2_addr);
        end
        @(negedge clk);
        n_cmp++; if ({bus.rf_write_enabled, bus.done, bus.rf_write_addr, bus.rf_write_bus} !== {1'b1, 1'b1, 5'd5, 8'h80}) begin
            n_err++; $display("FAIL add_wb got we=%b done=%b a=%0d d=%h exp 1 1 5 80", bus.rf_write_enabled, bus.done, bus.rf_write_addr, bus.rf_write_bus);
        end
        n_cmp++; if ({bus.carry, bus.zero} !== 2'b00) begin n_err++; $display("FAIL add_flags got c=%b z=%b exp 0 0", bus.carry, bus.zero); end
        @(negedge clk);
        n_cmp++; if ({bus.cmd_ready, bus.done, bus.rf_write_enabled} !== 3'b100) begin
            n_err++; $display("FAIL add_after got rdy=%b done=%b we=%b exp 1 0 0", bus.cmd_ready, bus.done, bus.rf_write_enabled);
        end
        n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL add_done_pulses got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_sub_carry_zero();
        issue(OP_SUB, 5'd6, 5'd4, 5'd3, 8'h00, 1'b0);
        @(negedge clk);
        n_cmp++; if ({bus.rf_write_addr, bus.rf_write_bus, bus.carry, bus.zero} !== {5'd6, 8'h82, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL sub got a=%0d d=%h c=%b z=%b exp 6 82 1 0", bus.rf_write_addr, bus.rf_write_bus, bus.carry, bus.zero);
        end
        issue(OP_LDI, 5'd8, 5'd0, 5'd0, 8'hFF, 1'b0);
        n_cmp++; if ({bus.rf_write_bus, bus.carry, bus.zero} !== {8'hFF, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL ldi_ff got d=%h c=%b z=%b exp ff 0 0", bus.rf_write_bus, bus.carry, bus.zero);
        end
        issue(OP_ADD, 5'd9, 5'd8, 5'd4, 8'h00, 1'b0);
        @(negedge clk);
        n_cmp++; if ({bus.rf_write_addr, bus.rf_write_bus, bus.carry, bus.zero} !== {5'd9, 8'h00, 1'b1, 1'b1}) begin
            n_err++; $display("FAIL add_wrap got a=%0d d=%h c=%b z=%b exp 9 00 1 1", bus.rf_write_addr, bus.rf_write_bus, bus.carry, bus.zero);
        end
    endtask

    task automatic test_back_to_back();
        issue(OP_ADD, 5'd11, 5'd3, 5'd4, 8'h00, 1'b1);
        bus.cmd_op = OP_MOV; bus.cmd_rd = 5'd7; bus.cmd_rs1 = 5'd5; bus.cmd_rs2 = 5'd0;
        n_cmp++; if (bus.cmd_ready !== 1'b0) begin n_err++; $display("FAIL b2b_c1_ready got=%b exp=0", bus.cmd_ready); end
        @(negedge clk);
        n_cmp++; if ({bus.cmd_ready, bus.rf_write_addr, bus.rf_write_bus} !== {1'b0, 5'd11, 8'h80}) begin
            n_err++; $display("FAIL b2b_c2 got rdy=%b a=%0d d=%h exp 0 11 80", bus.cmd_ready, bus.rf_write_addr, bus.rf_write_bus);
        end
        @(negedge clk);
        n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL b2b_c3_ready got=%b exp=1", bus.cmd_ready); end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        n_cmp++; if ({bus.cmd_ready, bus.rf_read_1_addr} !== {1'b0, 5'd5}) begin
            n_err++; $display("FAIL b2b_mov_read got rdy=%b r1=%0d exp 0 5", bus.cmd_ready, bus.rf_read_1_addr);
        end
        @(negedge clk);
        n_cmp++; if ({bus.rf_write_enabled, bus.rf_write_addr, bus.rf_write_bus} !== {1'b1, 5'd7, 8'h80}) begin
            n_err++; $display("FAIL b2b_mov_wb got we=%b a=%0d d=%h exp 1 7 80", bus.rf_write_enabled, bus.rf_write_addr, bus.rf_write_bus);
        end
        issue(OP_XOR, 5'd7, 5'd7, 5'd7, 8'h00, 1'b0);
        @(negedge clk);
        n_cmp++; if ({bus.rf_write_addr, bus.rf_write_bus, bus.carry, bus.zero} !== {5'd7, 8'h00, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL xor_self got a=%0d d=%h c=%b z=%b exp 7 00 0 1", bus.rf_write_addr, bus.rf_write_bus, bus.carry, bus.zero);
        end
    endtask

    task automatic test_clear();
        clear_monitor();
        issue(OP_CLR, 5'd0, 5'd0, 5'd0, 8'h00, 1'b0);
        for (int c = 1; c <= 32; c++) begin
            n_cmp++;
            if ({bus.rf_write_enabled, bus.rf_write_addr, bus.rf_write_bus, bus.cmd_ready, bus.done, bus.carry, bus.zero}
                !== {1'b1, 5'(c - 1), 8'h00, 1'b0, (c == 32), 1'b0, 1'b1}) begin
                n_err++;
                $display("FAIL clr_cycle%0d got we=%b a=%0d d=%h rdy=%b done=%b c=%b z=%b exp 1 %0d 00 0 %0d 0 1",
                         c, bus.rf_write_enabled, bus.rf_write_addr, bus.rf_write_bus, bus.cmd_ready, bus.done,
                         bus.carry, bus.zero, c - 1, (c == 32));
            end
            @(negedge clk);
        end
        n_cmp++; if ({bus.rf_write_enabled, bus.done, bus.cmd_ready} !== 3'b001) begin
            n_err++; $display("FAIL clr_end got we=%b done=%b rdy=%b exp 0 0 1", bus.rf_write_enabled, bus.done, bus.cmd_ready);
        end
        n_cmp++; if (wr_cnt !== 32 || done_cnt !== 1) begin n_err++; $display("FAIL clr_counts got writes=%0d dones=%0d exp 32 1", wr_cnt, done_cnt); end
        issue(OP_MOV, 5'd12, 5'd5, 5'd0, 8'h00, 1'b0);
        @(negedge clk);
        n_cmp++; if ({bus.rf_write_addr, bus.rf_write_bus, bus.zero} !== {5'd12, 8'h00, 1'b1}) begin
            n_err++; $display("FAIL clr_mov got a=%0d d=%h z=%b exp 12 00 1", bus.rf_write_addr, bus.rf_write_bus, bus.zero);
        end
    endtask

    task automatic test_reset_mid_cmd();
        issue(OP_LDI, 5'd13, 5'd0, 5'd0, 8'h3C, 1'b0);
        issue(OP_LDI, 5'd14, 5'd0, 5'd0, 8'h55, 1'b0);
        clear_monitor();
        issue(OP_ADD, 5'd14, 5'd13, 5'd13, 8'h00, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if ({bus.rf_write_enabled, bus.done, bus.cmd_ready} !== 3'b000) begin
            n_err++; $display("FAIL rst_add got we=%b done=%b rdy=%b exp 0 0 0", bus.rf_write_enabled, bus.done, bus.cmd_ready);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_add_ready got=%b exp=1", bus.cmd_ready); end
        n_cmp++; if (rf[14] !== 8'h55 || wr_cnt !== 0) begin n_err++; $display("FAIL rst_add_dest got r14=%h writes=%0d exp 55 0", rf[14], wr_cnt); end

        rf_fill = 1'b1; mon_clr = 1'b1;
        @(negedge clk);
        rf_fill = 1'b0; mon_clr = 1'b0;
        issue(OP_CLR, 5'd0, 5'd0, 5'd0, 8'h00, 1'b0);
        repeat (9) @(negedge clk);
        n_cmp++; if (bus.rf_write_addr !== 5'd9) begin n_err++; $display("FAIL rst_clr_pos got=%0d exp=9", bus.rf_write_addr); end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if ({bus.rf_write_enabled, bus.done} !== 2'b00) begin n_err++; $display("FAIL rst_clr_we got we=%b done=%b exp 0 0", bus.rf_write_enabled, bus.done); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_clr_ready got=%b exp=1", bus.cmd_ready); end
        n_cmp++; if (wr_seen !== 32'h0000_03FF || wr_cnt !== 10) begin n_err++; $display("FAIL rst_clr_span got seen=%h writes=%0d exp 000003ff 10", wr_seen, wr_cnt); end
        n_cmp++; if ({rf[9], rf[10], rf[31]} !== {8'h00, 8'hA5, 8'hA5}) begin
            n_err++; $display("FAIL rst_clr_data got r9=%h r10=%h r31=%h exp 00 a5 a5", rf[9], rf[10], rf[31]);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_ldi_add();
        test_sub_carry_zero();
        test_back_to_back();
        test_clear();
        test_reset_mid_cmd();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/regfile_sequencer.md
# regfile_sequencer

Command-driven initiator for the 2-read/1-write register file. Accepts one register-transfer command at a time over a valid/ready handshake, drives the register file read addresses, computes the result with a small internal ALU, and issues the single-cycle write-back. It also offers a CLR command that zero-fills every register with a write sweep. It sits between the control/test front-end and the register file's address/data ports.

## Interface
- `ADDR_WIDTH`, 5, register address width; register count is N = 2**ADDR_WIDTH
- `REG_WIDTH`, 8, data width
- `clk` in 1: single clock, all state updates on the rising edge
- `reset` in 1: synchronous, active-low reset
- `cmd_valid` in 1: command present
- `cmd_ready` out 1: sequencer can accept a command
- `cmd_op` in 3: opcode (ADD 000, SUB 001, AND 010, OR 011, XOR 100, MOV 101, LDI 110, CLR 111)
- `cmd_rd`, `cmd_rs1`, `cmd_rs2` in ADDR_WIDTH: destination and sources
- `cmd_imm` in REG_WIDTH: immediate, LDI only
- `rf_read_1_addr`, `rf_read_2_addr` out ADDR_WIDTH: register file read addresses
- `rf_read_bus_1`, `rf_read_bus_2` in REG_WIDTH: register file read data (combinational from address)
- `rf_write_addr` out ADDR_WIDTH, `rf_write_bus` out REG_WIDTH, `rf_write_enabled` out 1: write port
- `done` out 1: one-cycle pulse when a command finishes
- `carry`, `zero` out 1: flags from the last non-CLR command

## Operation
- States: IDLE, READ, WB, CLEAR. `cmd_ready` = (state == IDLE) && `reset` high.
- Accept = `cmd_valid && cmd_ready` at a rising edge. Latch op/rd/rs1/rs2/imm. Unused fields are ignored.
- IDLE -> READ for ALU ops and MOV. IDLE -> WB for LDI, with result = imm. IDLE -> CLEAR for CLR.
- READ: drive `rf_read_1_addr`=rs1 and `rf_read_2_addr`=rs2 from registers. At the end of the cycle, compute from the read buses, register the result and flags, then go to WB.
- ALU rules, all modulo 2**REG_WIDTH:
  - ADD: carry = carry-out.
  - SUB a-b: carry = borrow, i.e. 1 when a<b unsigned.
  - AND/OR/XOR/MOV: carry = 0. MOV result = a.
  - LDI: carry = 0.
  - zero = (result == 0) for every op except CLR.
- WB: `rf_write_enabled`=1, `rf_write_addr`=rd, `rf_write_bus`=result, `done`=1 for exactly one cycle. Then go to IDLE.
- CLEAR:
  - Counter runs 0..N-1, one address per cycle.
  - Each cycle drives `rf_write_enabled`=1, `rf_write_bus`=0, `rf_write_addr`=counter.
  - `done` asserts on the cycle that writes N-1, then the state goes to IDLE.
  - Flags hold their previous values.
- `rf_write_enabled` is 0 in every state other than WB and CLEAR. Read addresses hold their last value outside READ.
- The sequencer never drives the register file reset.

## Timing
- Reset (`reset` low at an edge) forces:
  - state = IDLE
  - all outputs 0: addresses, write bus, `rf_write_enabled`, `done`, `carry`, `zero`
  - `cmd_ready` = 0 while `reset` is low
- Reset mid-command abandons the command. No write enable is asserted after the reset edge. A partially completed CLEAR leaves the remaining registers untouched.
- Accept edge = cycle 0.
  - ALU/MOV: READ in cycle 1, WB + `done` in cycle 2. `cmd_ready` returns in cycle 3, so the throughput is 1 command per 3 cycles.
  - LDI: WB + `done` in cycle 1, ready in cycle 2.
  - CLR: writes in cycles 1..N, `done` in cycle N, ready in cycle N+1.
- No hazards. A write commits at the edge ending WB, before any later READ can occur, so a dependent command always sees the new value.
- `cmd_valid` held high through a command is not re-sampled until `cmd_ready`=1.

## Structure
- Package `regfile_seq_pkg`: opcode localparams, FSM state encoding.
- Sub-module `seq_alu`: combinational, (op, a, b, imm) -> (result, carry, zero), width REG_WIDTH.
- Top holds the FSM, command latch, result/flag registers and CLEAR counter.

## Test plan
- Reset: hold `reset` low 2 cycles -> every output 0 and `cmd_ready`=0. Release -> `cmd_ready`=1 on the next cycle.
- LDI r3=0x7F, LDI r4=0x01, ADD r5=r3+r4 -> write 0x80 to addr 5 in cycle 2 of the ADD; carry=0, zero=0, one `done` pulse.
- SUB r6=r4-r3 -> 0x82 with carry=1. Then LDI r8=0xFF, ADD r9=r8+r4 -> 0x00 with zero=1, carry=1.
- Back-to-back with `cmd_valid` held: ADD then MOV r7=r5. The second command is accepted in cycle 3 and writes 0x80 to r7. XOR r7,r7 -> 0x00, zero=1.
- CLR, N=32 -> `rf_write_enabled` high for 32 consecutive cycles at addresses 0..31 with data 0. `done` in cycle 32, `cmd_ready` low throughout, flags unchanged; subsequent MOV reads return 0.
- Reset asserted in cycle 1 of an ADD -> no write, destination unchanged. Reset during CLR at address 10 -> addresses 10..31 never written, IDLE after release.
